// File: rtl/ahb_pkg.sv
// Shared AHB types plus the arbiter's state encoding and burst-length decode.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } trans_t;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } burst_t;

   typedef enum logic [1:0] {
      ARB_PARK,
      ARB_BURST,
      ARB_UNDEF
   } arb_state_t;

   localparam int unsigned BEAT_W = 5;

   // Zero marks bursts with no fixed length (SINGLE, INCR).
   function automatic logic [BEAT_W-1:0] burst_len(input burst_t b);
      case (b)
         WRAP4, INCR4:   burst_len = BEAT_W'(4);
         WRAP8, INCR8:   burst_len = BEAT_W'(8);
         WRAP16, INCR16: burst_len = BEAT_W'(16);
         default:        burst_len = '0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Round-robin pick: first requester after 'last', wrapping to 'last'; parks on 'last' if none request.
module ahb_rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned MW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [MW-1:0] last,
   output logic [MW-1:0] next
);

   logic [MW-1:0] idx;

   // Scan from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      next = last;
      idx  = '0;
      for (int unsigned i = N; i >= 1; i--) begin
         idx = MW'((32'(last) + i) % N);
         if (req[idx]) next = idx;
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: burst-aware round-robin grant with address- and data-phase owner tracking.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned MW = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     hbusreq,
   input  trans_t [N-1:0]   htrans,
   input  burst_t [N-1:0]   hburst,
   input  logic             hready,
   output logic [N-1:0]     hgrant,
   output logic [MW-1:0]    hmaster,
   output logic [MW-1:0]    hmaster_d
);

   arb_state_t        state_q, state_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic [BEAT_W-1:0] len_q, len_d;
   logic [MW-1:0]     owner_q, owner_d;
   logic [MW-1:0]     downer_q, downer_d;
   logic [N-1:0]      grant_q, grant_d;
   logic [MW-1:0]     rr_next;
   logic [BEAT_W-1:0] nonseq_len;
   logic              restart;
   trans_t            o_trans;
   burst_t            o_burst;

   ahb_rr_pick #(.N(N), .MW(MW)) u_rr (
      .req  (hbusreq),
      .last (owner_q),
      .next (rr_next)
   );

   always_comb begin
      o_trans    = htrans[owner_q];
      o_burst    = hburst[owner_q];
      nonseq_len = burst_len(o_burst);
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      owner_d    = owner_q;
      downer_d   = downer_q;
      grant_d    = grant_q;
      restart    = 1'b0;

      if (hready) begin
         downer_d = owner_q;
         case (state_q)
            ARB_PARK: restart = 1'b1;
            ARB_BURST: begin
               case (o_trans)
                  SEQ: begin
                     if (cnt_q == len_q - BEAT_W'(1)) state_d = ARB_PARK;
                     else                             cnt_d   = cnt_q + BEAT_W'(1);
                  end
                  BUSY:    cnt_d   = cnt_q;
                  IDLE:    state_d = ARB_PARK;
                  default: restart = 1'b1;
               endcase
            end
            ARB_UNDEF: begin
               if (!hbusreq[owner_q] || o_trans == IDLE) state_d = ARB_PARK;
               else if (o_trans == NONSEQ)                restart = 1'b1;
            end
            default: state_d = ARB_PARK;
         endcase

         // A NONSEQ seen while parked or terminating a burst is classified in the same cycle.
         if (restart) begin
            state_d = ARB_PARK;
            if (o_trans == NONSEQ) begin
               if (nonseq_len != '0) begin
                  state_d = ARB_BURST;
                  cnt_d   = BEAT_W'(1);
                  len_d   = nonseq_len;
               end else if (o_burst == INCR) begin
                  state_d = ARB_UNDEF;
               end
            end
         end

         if (state_d == ARB_PARK) begin
            cnt_d            = '0;
            owner_d          = rr_next;
            grant_d          = '0;
            grant_d[rr_next] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_PARK;
         cnt_q    <= '0;
         len_q    <= '0;
         owner_q  <= '0;
         downer_q <= '0;
         grant_q  <= {{(N-1){1'b0}}, 1'b1};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         owner_q  <= owner_d;
         downer_q <= downer_d;
         grant_q  <= grant_d;
      end
   end

   assign hgrant    = grant_q;
   assign hmaster   = owner_q;
   assign hmaster_d = downer_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;
  import ahb_pkg::*;

  typedef struct packed {
    logic        sel;
    logic [3:0]  g;
    logic [1:0]  m;
    logic [1:0]  md;
    logic [63:0] tag;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         hready;
  logic [3:0]   hbusreq;
  trans_t [3:0] htrans;
  burst_t [3:0] hburst;

  logic [1:0]   g2;
  logic [0:0]   m2, md2;
  logic [3:0]   g4;
  logic [1:0]   m4, md4;

  exp_t         sb[$];
  exp_t         e;
  logic [3:0]   ag;
  logic [1:0]   am, amd;
  int           n_tests  = 0;
  int           n_fail   = 0;
  int           n_queued = 0;

  ahb_arbiter #(.N(2)) u_arb2 (
    .clk       (clk),
    .reset     (reset),
    .hbusreq   (hbusreq[1:0]),
    .htrans    (htrans[1:0]),
    .hburst    (hburst[1:0]),
    .hready    (hready),
    .hgrant    (g2),
    .hmaster   (m2),
    .hmaster_d (md2)
  );

  ahb_arbiter #(.N(4)) u_arb4 (
    .clk       (clk),
    .reset     (reset),
    .hbusreq   (hbusreq),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (g4),
    .hmaster   (m4),
    .hmaster_d (md4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        ag = g4; am = m4; amd = md4;
      end else begin
        ag = {2'b00, g2}; am = {1'b0, m2}; amd = {1'b0, md2};
      end
      n_tests++;
      if (ag !== e.g || am !== e.m || amd !== e.md) begin
        n_fail++;
        $display("FAIL %s: hgrant=%b hmaster=%0d hmaster_d=%0d, expected hgrant=%b hmaster=%0d hmaster_d=%0d",
                 e.tag, ag, am, amd, e.g, e.m, e.md);
      end
      n_tests++;
      if ($countones(g2) != 1 || $countones(g4) != 1 || $isunknown({g2, g4})) begin
        n_fail++;
        $display("FAIL %s: hgrant not one-hot (N=2 %b, N=4 %b)", e.tag, g2, g4);
      end
    end
  end

  task automatic cyc(input logic rst, input logic rdy, input logic [3:0] req, input int unsigned own,
                     input trans_t tr, input burst_t bu, input logic sel,
                     input logic [3:0] eg, input logic [1:0] em, input logic [1:0] emd,
                     input logic [63:0] tag);
    exp_t x;
    @(posedge clk);
    #1;
    reset   = rst;
    hready  = rdy;
    hbusreq = req;
    for (int unsigned i = 0; i < 4; i++) begin
      htrans[i] = IDLE;
      hburst[i] = SINGLE;
    end
    htrans[own] = tr;
    hburst[own] = bu;
    x.sel = sel; x.g = eg; x.m = em; x.md = emd; x.tag = tag;
    sb.push_back(x);
    n_queued++;
  endtask

  initial begin
    reset   = 1'b1;
    hready  = 1'b1;
    hbusreq = 4'b0000;
    for (int unsigned i = 0; i < 4; i++) begin
      htrans[i] = IDLE;
      hburst[i] = SINGLE;
    end

    repeat (3)  cyc(1'b1, 1'b1, 4'b0000, 0, IDLE, SINGLE, 1'b0, 4'b0001, 2'd0, 2'd0, "rst");
    repeat (10) cyc(1'b0, 1'b1, 4'b0000, 0, IDLE, SINGLE, 1'b0, 4'b0001, 2'd0, 2'd0, "idle");

    cyc(1'b0, 1'b1, 4'b0011, 0, NONSEQ, INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "incr4");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "incr4");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "incr4");
    cyc(1'b0, 1'b1, 4'b0010, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "incr4");
    cyc(1'b0, 1'b1, 4'b0000, 1, IDLE,   SINGLE, 1'b0, 4'b0010, 2'd1, 2'd0, "incr4");
    cyc(1'b0, 1'b1, 4'b0001, 1, IDLE,   SINGLE, 1'b0, 4'b0010, 2'd1, 2'd1, "incr4");
    cyc(1'b0, 1'b1, 4'b0000, 0, IDLE,   SINGLE, 1'b0, 4'b0001, 2'd0, 2'd1, "incr4");

    cyc(1'b0, 1'b1, 4'b0011, 0, NONSEQ, INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "wait");
    cyc(1'b0, 1'b0, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "wait");
    cyc(1'b0, 1'b0, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "wait");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "wait");
    cyc(1'b0, 1'b1, 4'b0011, 0, BUSY,   INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "wait");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "wait");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "wait");
    cyc(1'b0, 1'b1, 4'b0000, 1, IDLE,   SINGLE, 1'b0, 4'b0010, 2'd1, 2'd0, "wait");

    cyc(1'b0, 1'b1, 4'b0011, 1, NONSEQ, INCR,   1'b0, 4'b0010, 2'd1, 2'd1, "undef");
    repeat (6) cyc(1'b0, 1'b1, 4'b0011, 1, SEQ, INCR, 1'b0, 4'b0010, 2'd1, 2'd1, "undef");
    cyc(1'b0, 1'b1, 4'b0011, 1, IDLE,   SINGLE, 1'b0, 4'b0010, 2'd1, 2'd1, "undef");
    cyc(1'b0, 1'b1, 4'b0000, 0, IDLE,   SINGLE, 1'b0, 4'b0001, 2'd0, 2'd1, "undef");

    cyc(1'b0, 1'b1, 4'b0010, 0, IDLE,   SINGLE, 1'b0, 4'b0001, 2'd0, 2'd0, "rstmid");
    cyc(1'b0, 1'b1, 4'b0011, 1, NONSEQ, INCR8,  1'b0, 4'b0010, 2'd1, 2'd0, "rstmid");
    cyc(1'b0, 1'b1, 4'b0011, 1, SEQ,    INCR8,  1'b0, 4'b0010, 2'd1, 2'd1, "rstmid");
    cyc(1'b1, 1'b1, 4'b0011, 1, SEQ,    INCR8,  1'b0, 4'b0001, 2'd0, 2'd0, "rstmid");
    cyc(1'b1, 1'b1, 4'b0011, 1, SEQ,    INCR8,  1'b0, 4'b0001, 2'd0, 2'd0, "rstmid");
    cyc(1'b0, 1'b1, 4'b0011, 0, NONSEQ, INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "rstmid");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "rstmid");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "rstmid");
    cyc(1'b0, 1'b1, 4'b0011, 0, SEQ,    INCR4,  1'b0, 4'b0001, 2'd0, 2'd0, "rstmid");
    cyc(1'b0, 1'b1, 4'b0000, 1, IDLE,   SINGLE, 1'b0, 4'b0010, 2'd1, 2'd0, "rstmid");

    cyc(1'b0, 1'b1, 4'b0011, 1, NONSEQ, INCR,   1'b0, 4'b0010, 2'd1, 2'd1, "udrop");
    cyc(1'b0, 1'b1, 4'b0011, 1, SEQ,    INCR,   1'b0, 4'b0010, 2'd1, 2'd1, "udrop");
    cyc(1'b0, 1'b1, 4'b0001, 1, SEQ,    INCR,   1'b0, 4'b0010, 2'd1, 2'd1, "udrop");
    cyc(1'b0, 1'b1, 4'b0000, 0, IDLE,   SINGLE, 1'b0, 4'b0001, 2'd0, 2'd1, "udrop");
    cyc(1'b0, 1'b1, 4'b0000, 0, IDLE,   SINGLE, 1'b0, 4'b0001, 2'd0, 2'd0, "udrop");

    repeat (2) cyc(1'b1, 1'b1, 4'b0000, 0, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, "rr4rst");
    for (int unsigned k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 4'b1111, k % 4, NONSEQ, SINGLE, 1'b1,
          4'(1 << (k % 4)), 2'(k % 4), (k == 0) ? 2'd0 : 2'((k + 3) % 4), "rr4");
    end
    cyc(1'b0, 1'b1, 4'b0000, 0, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd3, "rr4");

    @(negedge clk);
    #1;
    if (sb.size() != 0 || n_tests != 2 * n_queued) begin
      n_fail++;
      $display("FAIL end: %0d vectors left unchecked, %0d checks for %0d vectors",
               sb.size(), n_tests, n_queued);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter N, default 2: number of AHB masters sharing the bus; legal range 2..8.
REQ-002 Parameter MW, default $clog2(N): width of the master index.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 hbusreq  input  N  per-master bus request, level-sensitive.
REQ-006 htrans  input  N x trans_t  per-master transfer type, as driven by each master.
REQ-007 hburst  input  N x burst_t  per-master burst type, qualified by that master's NONSEQ.
REQ-008 hready  input  1  shared bus ready; high means the current address and data phases complete this cycle.
REQ-009 hgrant  output  N  one-hot grant, registered.
REQ-010 hmaster  output  MW  index of the address-phase owner; always equals the index of the set bit in hgrant.
REQ-011 hmaster_d  output  MW  index of the data-phase owner, used for the write-data and response muxes.

Function
REQ-012 Arbitration decisions are taken only in cycles with hready=1; with hready=0 all state and outputs hold.
REQ-013 The owner's transfer (o_trans = htrans[hmaster], o_burst = hburst[hmaster]) is classified every cycle.
REQ-014 State machine states:
  - PARK: no burst in progress.
  - BURST: fixed-length burst in progress; used for INCR4/8/16 and WRAP4/8/16.
  - UNDEF: undefined-length INCR burst in progress.
REQ-015 PARK transitions with hready=1:
  - o_trans=NONSEQ, fixed-length burst: go to BURST, beat counter = 1.
  - o_trans=NONSEQ, burst INCR: go to UNDEF.
  - Otherwise (IDLE, or NONSEQ SINGLE): stay in PARK.
REQ-016 BURST: the beat counter increments on each SEQ with hready=1 and holds on BUSY. Burst length L is 4, 8 or 16, taken from burst_t and latched at the NONSEQ. WRAP bursts are counted identically to INCR bursts.
REQ-017 BURST exits to PARK on:
  - the SEQ beat accepted with counter == L-1 (last beat), or
  - an owner IDLE or NONSEQ (early termination); a NONSEQ also restarts classification as in PARK in the same cycle.
REQ-018 UNDEF exits to PARK when hready=1 and o_trans is IDLE, or when hbusreq[hmaster]=0; it holds on SEQ and BUSY.
REQ-019 An arbitration point is a cycle with hready=1 in which the machine is, or is entering, PARK; no arbitration point occurs while in BURST or UNDEF.
REQ-020 At an arbitration point, the next owner is the first requesting master in round-robin order, starting at (hmaster+1) mod N and wrapping to hmaster last.
REQ-021 If no master requests, the grant parks on the current owner, i.e. it does not change.
REQ-022 A grant change takes effect on the clock edge after the arbitration point: hgrant and hmaster update together, and the beat counter clears.
REQ-023 hmaster_d is loaded with hmaster on every edge where hready=1, so the data-phase owner always lags the address-phase owner by one accepted transfer.
REQ-024 Simultaneous events:
  - Owner deasserts hbusreq at a burst's last beat while another master requests: the grant switches normally.
  - Owner issues a NONSEQ SINGLE at an arbitration point: that transfer is accepted, then the grant moves.
REQ-025 hgrant is exactly one-hot in every cycle, including immediately after reset.

Reset
REQ-026 While reset=1:
  - hgrant = 1 (master 0),
  - hmaster = 0, hmaster_d = 0,
  - state = PARK, beat counter = 0.
REQ-027 Reset asserted mid-burst aborts the burst immediately, with no grant handover sequencing; after release, arbitration resumes from master 0 on the first cycle with hready=1.

Structure
REQ-028 burst_t and trans_t come from AHB_PKG.
REQ-029 The arbiter state enum and a function mapping burst_t to beat length (0 for SINGLE/INCR) are added to AHB_PKG.
REQ-030 Round-robin selection is a separate sub-module, ahb_rr_pick, with inputs req[N] and last[MW] and output next[MW], combinational only.

Verification
REQ-031 Reset: release reset with no requests, hready=1 -> hgrant=01 and hmaster=0 held for 10 cycles.
REQ-032 INCR4 burst (N=2): master 0 issues NONSEQ/INCR4, then SEQ x3 with hready=1, while master 1 requests throughout -> hgrant stays 01 until the edge after the third SEQ, then becomes 10; hmaster_d=0 during master 0's last data phase.
REQ-033 Wait states: the same INCR4 with hready=0 for 2 cycles on beat 2 and one BUSY inserted -> handover is delayed by exactly 3 cycles relative to REQ-032.
REQ-034 Round-robin fairness (N=4): all hbusreq held high, every master issues NONSEQ SINGLE -> hmaster sequence is 0,1,2,3,0,1...
REQ-035 Undefined INCR: master 1 issues NONSEQ/INCR followed by 6 SEQ, with master 0 requesting -> no switch occurs; when master 1 drives IDLE with hready=1, hgrant becomes 01 on the next edge.
REQ-036 Reset mid-burst: assert reset at beat 2 of an INCR8 owned by master 1 -> hgrant=01 while reset is high; after release, a new NONSEQ from master 0 is counted from beat 1.
